systolic_engine: RTL and testbench
==================================

SYSTOLIC_ENGINE -- requirements
Module: systolic_engine

Interface
REQ-001 SHALL have parameter ROWS, default `ARRAY_ROW, number of PE rows (activation lanes).
REQ-002 SHALL have parameter COLS, default `ARRAY_COL, number of PE columns (output lanes).
REQ-003 SHALL have parameter DATA_W, default `DATA_WIDTH, signed activation/weight width.
REQ-004 SHALL have parameter ACC_W, default `ACC_WIDTH, signed partial-sum width.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 in_valid  in  1  in_act_vec holds one unskewed activation vector.
REQ-008 in_ready  out  1  engine accepts a vector this cycle.
REQ-009 in_act_vec  in  ROWS*DATA_W  row r at bits [r*DATA_W +: DATA_W], signed.
REQ-010 w_load_en  in  1  write w_data into shadow weight row w_row_idx.
REQ-011 w_row_idx  in  clog2(ROWS)  target shadow row; values >= ROWS ignored.
REQ-012 w_data  in  COLS*DATA_W  column c at bits [c*DATA_W +: DATA_W], signed.
REQ-013 w_swap  in  1  pulse: request shadow-to-active weight commit.
REQ-014 swap_busy  out  1  swap requested, not yet committed.
REQ-015 out_valid  out  1  out_psum_vec holds one aligned result vector.
REQ-016 out_psum_vec  out  COLS*ACC_W  column c at bits [c*ACC_W +: ACC_W], signed.

Function
REQ-017 SHALL compute out[c] = sum over r of act[r]*w_active[r][c], signed, sign-extended to ACC_W, two's-complement wrap on overflow.
REQ-018 SHALL skew inputs internally: row r delayed r cycles; SHALL deskew outputs: column c delayed COLS-1-c cycles.
REQ-019 Accepted vector (in_valid & in_ready) at cycle T SHALL appear with out_valid=1 at exactly T+LAT, LAT = ROWS+COLS.
REQ-020 Cycles without acceptance SHALL inject zero activations and yield out_valid=0 at the matching output cycle; results never reorder.
REQ-021 Valid SHALL be tracked by an LAT-deep valid shift register; in-flight count = number of set bits.
REQ-022 FSM states RUN, DRAIN, SWAP; reset state RUN.
REQ-023 RUN: in_ready=1; w_swap -> DRAIN (swap_busy=1 next cycle).
REQ-024 DRAIN: in_ready=0; when in-flight count = 0 -> SWAP.
REQ-025 SWAP: one cycle; copy all shadow rows to active rows; in_ready=0; -> RUN, swap_busy=0 next cycle.
REQ-026 w_swap while swap_busy=1 SHALL be ignored (merged into pending swap).
REQ-027 w_load_en SHALL be accepted in every state; a load in the SWAP cycle writes shadow after the copy (effective at next swap).
REQ-028 w_swap and in_valid in the same RUN cycle: that vector SHALL be accepted and computed with old weights.
REQ-029 Active weights SHALL never change while any valid vector is in flight.

Reset
REQ-030 rst_n=0 SHALL clear state to RUN, swap_busy=0, valid pipeline, skew/deskew and psum registers to 0, out_valid=0, out_psum_vec=0, in_ready=1 after reset release.
REQ-031 Reset mid-stream SHALL discard all in-flight vectors; no out_valid after release until a new acceptance plus LAT.
REQ-032 Reset SHALL clear active and shadow weights to 0.

Structure
REQ-033 ROWS/COLS/width defaults SHALL come from params.vh (`ARRAY_ROW, `ARRAY_COL, `DATA_WIDTH, `ACC_WIDTH); FSM state encodings local.
REQ-034 SHALL instantiate one sub-module sa_pe (shadow+active weight reg, MAC, act/psum forwarding) in a ROWS x COLS generate grid.

Verification
REQ-035 Identity weights, ROWS=COLS, in_act_vec = {1..ROWS} -> out_psum_vec[c] = c+1 at T+LAT, out_valid single pulse.
REQ-036 All weights 1, 32 back-to-back vectors all 127 (ROWS=12) -> 32 consecutive outputs each column 1524.
REQ-037 All weights -128, activations -128, ROWS=12 -> each column 196608; weights 127, acts -128 -> -195072.
REQ-038 Alternate in_valid 1/0 over 20 cycles -> out_valid pattern identical, delayed LAT, values match golden.
REQ-039 Stream 10 vectors, w_swap with 5th -> 5th uses old weights, in_ready low until LAT cycles after last acceptance+1, next vector uses new weights.
REQ-040 rst_n low 1 cycle while 8 vectors in flight -> out_valid stays 0 for 2*LAT cycles, outputs 0.

Source files
------------

// File: rtl/systolic_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_engine_pkg
// Purpose  : Shared array defaults and sizing helpers for the systolic engine.
// Revision : 1.0 - initial release
// ============================================================================

// Fallback array defaults, normally supplied by params.vh.
`ifndef ARRAY_ROW
`define ARRAY_ROW 12
`endif
`ifndef ARRAY_COL
`define ARRAY_COL 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 32
`endif

package systolic_engine_pkg;

  localparam int C_MIN_IDX_W = 1;

  // Input-to-output latency: skew + array traversal + deskew + output register.
  function automatic int calc_lat(input int rows, input int cols);
    return rows + cols;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : C_MIN_IDX_W;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sa_pe.sv
`default_nettype none
// ============================================================================
// Module   : sa_pe
// Purpose  : Weight-stationary PE: shadow/active weights, MAC, act/psum forward.
// Revision : 1.0 - initial release
// ============================================================================

module sa_pe #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_w_load,
  input  logic [DATA_W-1:0]        i_w,
  input  logic                     i_commit,
  input  logic [DATA_W-1:0]        i_act,
  output logic [DATA_W-1:0]        o_act,
  input  logic signed [ACC_W-1:0]  i_psum,
  output logic signed [ACC_W-1:0]  o_psum
);

  logic signed [DATA_W-1:0]   r_w_shadow;
  logic signed [DATA_W-1:0]   r_w_active;
  logic [DATA_W-1:0]          r_act;
  logic signed [ACC_W-1:0]    r_psum;
  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;

  assign w_prod     = $signed(i_act) * r_w_active;
  assign w_prod_ext = ACC_W'(w_prod);

  // Commit samples the shadow before a same-cycle load overwrites it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_w_shadow <= '0;
      r_w_active <= '0;
      r_act      <= '0;
      r_psum     <= '0;
    end else begin
      if (i_commit) r_w_active <= r_w_shadow;
      if (i_w_load) r_w_shadow <= i_w;
      r_act  <= i_act;
      r_psum <= i_psum + w_prod_ext;
    end
  end

  assign o_act  = r_act;
  assign o_psum = r_psum;

endmodule

`default_nettype wire

// File: rtl/systolic_engine.sv
`default_nettype none
// ============================================================================
// Module   : systolic_engine
// Purpose  : ROWS x COLS weight-stationary systolic array with skew/deskew and
//            drain-then-swap double-buffered weights.
// Revision : 1.0 - initial release
// ============================================================================

module systolic_engine
  import systolic_engine_pkg::*;
#(
  parameter int ROWS   = `ARRAY_ROW,
  parameter int COLS   = `ARRAY_COL,
  parameter int DATA_W = `DATA_WIDTH,
  parameter int ACC_W  = `ACC_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ROWS*DATA_W-1:0]      in_act_vec,
  input  logic                        w_load_en,
  input  logic [idx_width(ROWS)-1:0]  w_row_idx,
  input  logic [COLS*DATA_W-1:0]      w_data,
  input  logic                        w_swap,
  output logic                        swap_busy,
  output logic                        out_valid,
  output logic [COLS*ACC_W-1:0]       out_psum_vec
);

  localparam int LAT    = calc_lat(ROWS, COLS);
  localparam int RIDX_W = idx_width(ROWS);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2
  } state_t;

  state_t         r_state;
  logic           r_in_ready;
  logic           r_swap_busy;
  logic [LAT-1:0] r_vld_sr;
  logic           w_accept;
  logic           w_commit;
  logic           w_drained;

  assign w_accept  = in_valid & r_in_ready;
  assign w_commit  = (r_state == ST_SWAP);
  assign w_drained = ~|r_vld_sr;   // in-flight count == 0

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_in_ready  <= 1'b1;
      r_swap_busy <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_swap) begin
            r_state     <= ST_DRAIN;
            r_in_ready  <= 1'b0;
            r_swap_busy <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_drained) r_state <= ST_SWAP;
        end
        ST_SWAP: begin
          r_state     <= ST_RUN;
          r_in_ready  <= 1'b1;
          r_swap_busy <= 1'b0;
        end
        default: begin
          r_state     <= ST_RUN;
          r_in_ready  <= 1'b1;
          r_swap_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_vld_sr <= '0;
    else        r_vld_sr <= {r_vld_sr[LAT-2:0], w_accept};
  end

  assign in_ready  = r_in_ready;
  assign swap_busy = r_swap_busy;
  assign out_valid = r_vld_sr[LAT-1];

  logic [DATA_W-1:0]       w_act  [ROWS][COLS+1];
  logic signed [ACC_W-1:0] w_psum [ROWS+1][COLS];
  logic [ROWS-1:0]         w_unused_tail;

  // Input skew: row r enters the array r cycles late; bubbles inject zeros.
  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic [DATA_W-1:0] w_inj;
    assign w_inj = w_accept ? in_act_vec[r*DATA_W +: DATA_W] : '0;
    if (r == 0) begin : g_direct
      assign w_act[r][0] = w_inj;
    end else begin : g_delay
      logic [DATA_W-1:0] r_pipe [r];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < r; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= w_inj;
          for (int i = 1; i < r; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_act[r][0] = r_pipe[r-1];
    end
    assign w_unused_tail[r] = ^w_act[r][COLS];
  end

  for (genvar c = 0; c < COLS; c++) begin : g_top_psum
    assign w_psum[0][c] = '0;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sa_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_w_load (w_load_en && (w_row_idx == RIDX_W'(r))),
        .i_w      (w_data[c*DATA_W +: DATA_W]),
        .i_commit (w_commit),
        .i_act    (w_act[r][c]),
        .o_act    (w_act[r][c+1]),
        .i_psum   (w_psum[r][c]),
        .o_psum   (w_psum[r+1][c])
      );
    end
  end

  // Output deskew: column c finishes c cycles after column 0, so delay the rest.
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    localparam int DEPTH = COLS - 1 - c;
    logic signed [ACC_W-1:0] w_aligned;
    logic signed [ACC_W-1:0] r_out;
    if (DEPTH == 0) begin : g_direct
      assign w_aligned = w_psum[ROWS][c];
    end else begin : g_delay
      logic signed [ACC_W-1:0] r_pipe [DEPTH];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= w_psum[ROWS][c];
          for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_aligned = r_pipe[DEPTH-1];
    end
    always_ff @(posedge clk) begin
      if (!rst_n) r_out <= '0;
      else        r_out <= w_aligned;
    end
    assign out_psum_vec[c*ACC_W +: ACC_W] = r_out;
  end

endmodule

`default_nettype wire

// File: tb/tb_systolic_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_engine
// Purpose  : Self-checking bench: table vectors plus randomized reference model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_systolic_engine;

  localparam int ROWS   = 12;
  localparam int COLS   = 12;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int LAT    = ROWS + COLS;
  localparam int RIDX_W = $clog2(ROWS);

  typedef logic [ROWS*DATA_W-1:0] ivec_t;
  typedef logic [COLS*ACC_W-1:0]  ovec_t;
  typedef logic [COLS*DATA_W-1:0] wvec_t;
  typedef struct {
    ivec_t act;
    ovec_t exp;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  ivec_t             in_act_vec;
  logic              w_load_en;
  logic [RIDX_W-1:0] w_row_idx;
  wvec_t             w_data;
  logic              w_swap;
  logic              swap_busy;
  logic              out_valid;
  ovec_t             out_psum_vec;

  systolic_engine #(
    .ROWS   (ROWS),
    .COLS   (COLS),
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_act_vec   (in_act_vec),
    .w_load_en    (w_load_en),
    .w_row_idx    (w_row_idx),
    .w_data       (w_data),
    .w_swap       (w_swap),
    .swap_busy    (swap_busy),
    .out_valid    (out_valid),
    .out_psum_vec (out_psum_vec)
  );

  always #5 clk = ~clk;

  // Reference model state: weight matrices and expected outputs keyed by cycle.
  int    m_shd [ROWS][COLS];
  int    m_act [ROWS][COLS];
  ovec_t exp_d [int];
  int    cyc = 0, checks = 0, errs = 0;
  int    last_acc = -1000, swap_cyc = 0;
  bit    pending = 1'b0, ovr_en = 1'b0;
  ovec_t ovr_val;
  vec_t  tbl [6];

  function automatic ovec_t golden(input ivec_t a);
    ovec_t o;
    for (int c = 0; c < COLS; c++) begin
      longint s = 0;
      for (int r = 0; r < ROWS; r++)
        s += longint'($signed(a[r*DATA_W +: DATA_W])) * longint'(m_act[r][c]);
      o[c*ACC_W +: ACC_W] = s[ACC_W-1:0];
    end
    return o;
  endfunction

  function automatic ivec_t const_act(input int v);
    ivec_t a;
    for (int r = 0; r < ROWS; r++) a[r*DATA_W +: DATA_W] = DATA_W'(v);
    return a;
  endfunction

  function automatic ovec_t const_out(input int v);
    ovec_t o;
    for (int c = 0; c < COLS; c++) o[c*ACC_W +: ACC_W] = ACC_W'(v);
    return o;
  endfunction

  function automatic wvec_t const_w(input int v);
    wvec_t w;
    for (int c = 0; c < COLS; c++) w[c*DATA_W +: DATA_W] = DATA_W'(v);
    return w;
  endfunction

  function automatic wvec_t onehot_w(input int r);
    wvec_t w;
    for (int c = 0; c < COLS; c++) w[c*DATA_W +: DATA_W] = (c == r) ? DATA_W'(1) : '0;
    return w;
  endfunction

  function automatic ivec_t rand_act();
    ivec_t a;
    for (int r = 0; r < ROWS; r++) a[r*DATA_W +: DATA_W] = DATA_W'($urandom);
    return a;
  endfunction

  function automatic wvec_t rand_w();
    wvec_t w;
    for (int c = 0; c < COLS; c++) w[c*DATA_W +: DATA_W] = DATA_W'($urandom);
    return w;
  endfunction

  task automatic chk(input string name, input ovec_t act, input ovec_t req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask

  // One clock: record what the model expects, advance, then compare outputs.
  task automatic tick();
    bit acc;
    acc = rst_n && in_valid && in_ready;
    if (acc) begin
      exp_d[cyc + LAT] = ovr_en ? ovr_val : golden(in_act_vec);
      last_acc = cyc;
    end
    if (rst_n && w_load_en && (int'(w_row_idx) < ROWS))
      for (int c = 0; c < COLS; c++)
        m_shd[int'(w_row_idx)][c] = int'($signed(w_data[c*DATA_W +: DATA_W]));
    if (rst_n && w_swap && !pending) begin
      pending  = 1'b1;
      swap_cyc = cyc;
      m_act    = m_shd;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      exp_d.delete();
      pending = 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          m_shd[r][c] = 0;
          m_act[r][c] = 0;
        end
    end
    chk("out_valid", ovec_t'(out_valid), ovec_t'(exp_d.exists(cyc)));
    chk("out_psum", out_psum_vec, exp_d.exists(cyc) ? exp_d[cyc] : '0);
    if (exp_d.exists(cyc)) exp_d.delete(cyc);
    if (pending) begin
      if (in_ready) begin
        int lo, hi;
        lo = (last_acc + LAT + 1 > swap_cyc + 2) ? last_acc + LAT + 1 : swap_cyc + 2;
        hi = lo + 4;
        pending = 1'b0;
        checks++;
        if (cyc < lo || cyc > hi) begin
          errs++;
          $display("FAIL swap_ready_window: ready at cyc %0d, expected within %0d..%0d", cyc, lo, hi);
        end
        chk("swap_busy_clear", ovec_t'(swap_busy), '0);
      end else begin
        chk("swap_busy_set", ovec_t'(swap_busy), ovec_t'(1));
      end
    end else begin
      chk("in_ready", ovec_t'(in_ready), ovec_t'(1));
      chk("swap_busy", ovec_t'(swap_busy), '0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic load_row(input int r, input wvec_t d);
    w_load_en = 1'b1;
    w_row_idx = RIDX_W'(r);
    w_data    = d;
    tick();
    w_load_en = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (pending && n < 200) begin
      tick();
      n++;
    end
    if (pending) begin
      checks++;
      errs++;
      $display("FAIL swap_timeout: in_ready still 0 after %0d cycles, expected 1", n);
      pending = 1'b0;
    end
  endtask

  task automatic do_swap();
    w_swap = 1'b1;
    tick();
    w_swap = 1'b0;
    wait_ready();
  endtask

  task automatic send(input ivec_t a, input bit sw);
    int n = 0;
    bit acc;
    in_valid   = 1'b1;
    in_act_vec = a;
    w_swap     = sw;
    do begin
      acc = in_ready;
      tick();
      w_swap = 1'b0;
      n++;
    end while (!acc && n < 200);
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      errs++;
      $display("FAIL send_timeout: in_ready 0 for %0d cycles, expected 1", n);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_act_vec = '0;
    w_load_en = 1'b0; w_row_idx = '0; w_data = '0; w_swap = 1'b0;

    // Identity-weight table: output column c equals activation row c.
    for (int i = 0; i < 6; i++)
      for (int k = 0; k < ROWS; k++) begin
        int v;
        case (i)
          0:       v = k + 1;
          1:       v = 5;
          2:       v = -k;
          3:       v = 127;
          4:       v = -128;
          default: v = (k % 2 != 0) ? -100 : 100;
        endcase
        tbl[i].act[k*DATA_W +: DATA_W] = DATA_W'(v);
        tbl[i].exp[k*ACC_W +: ACC_W]   = ACC_W'(v);
      end

    idle(2);
    rst_n = 1'b1;
    idle(2);

    for (int r = 0; r < ROWS; r++) load_row(r, onehot_w(r));
    load_row(13, const_w(7));            // out-of-range row must be dropped
    do_swap();
    for (int i = 0; i < 6; i++) begin
      ovr_en  = 1'b1;
      ovr_val = tbl[i].exp;
      send(tbl[i].act, 1'b0);
      ovr_en  = 1'b0;
      idle(LAT + 1);
    end

    // All-ones weights, 32 back-to-back vectors of 127.
    for (int r = 0; r < ROWS; r++) load_row(r, const_w(1));
    do_swap();
    ovr_en  = 1'b1;
    ovr_val = const_out(1524);
    for (int i = 0; i < 32; i++) send(const_act(127), 1'b0);
    ovr_en = 1'b0;
    idle(LAT + 1);

    // Extreme products.
    for (int r = 0; r < ROWS; r++) load_row(r, const_w(-128));
    do_swap();
    ovr_en = 1'b1; ovr_val = const_out(196608);
    send(const_act(-128), 1'b0);
    ovr_en = 1'b0;
    idle(LAT + 1);
    for (int r = 0; r < ROWS; r++) load_row(r, const_w(127));
    do_swap();
    ovr_en = 1'b1; ovr_val = const_out(-195072);
    send(const_act(-128), 1'b0);
    ovr_en = 1'b0;
    idle(LAT + 1);

    // Random weights, alternating valid.
    for (int r = 0; r < ROWS; r++) load_row(r, rand_w());
    do_swap();
    for (int i = 0; i < 20; i++) begin
      in_valid   = (i % 2 == 0);
      in_act_vec = rand_act();
      tick();
    end
    in_valid = 1'b0;
    idle(LAT + 1);

    // Swap with the 5th of 10 streamed vectors; a second swap while busy is ignored.
    for (int r = 0; r < ROWS; r++) load_row(r, rand_w());
    for (int i = 0; i < 10; i++) send(rand_act(), (i == 4) || (i == 5));
    idle(LAT + 2);

    // Random traffic with one swap in the middle.
    for (int i = 0; i < 150; i++) begin
      in_valid   = ($urandom_range(0, 2) != 0);
      in_act_vec = rand_act();
      w_swap     = (i == 75);
      w_load_en  = !pending && ($urandom_range(0, 3) == 0);
      w_row_idx  = RIDX_W'($urandom_range(0, ROWS - 1));
      w_data     = rand_w();
      tick();
    end
    in_valid = 1'b0; w_swap = 1'b0; w_load_en = 1'b0;
    wait_ready();
    idle(LAT + 2);

    // Reset with 8 vectors in flight.
    for (int i = 0; i < 8; i++) send(rand_act(), 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle(2 * LAT);
    send(rand_act(), 1'b0);
    idle(LAT + 2);

    checks++;
    if (exp_d.size() != 0) begin
      errs++;
      $display("FAIL leftover_outputs: %0d expected results never seen, expected 0", exp_d.size());
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

`default_nettype wire
